// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUop decode values and the multiply sequencer state encoding.
package alu_pkg;

   localparam logic [2:0] ALUOP_AND = 3'b000;
   localparam logic [2:0] ALUOP_OR  = 3'b001;
   localparam logic [2:0] ALUOP_ADD = 3'b100;

   localparam logic [1:0] SEQ_IDLE = 2'd0;
   localparam logic [1:0] SEQ_RUN  = 2'd1;
   localparam logic [1:0] SEQ_DONE = 2'd2;

endpackage

// File: rtl/mult_shift_datapath.sv
// Shift-add multiply registers: {hi,lo} accumulator, captured multiplicand and the
// conditional add/shift mux fed by the shared ALU sum.
module mult_shift_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             stall,
   input  logic [WIDTH-1:0] load_a,
   input  logic [WIDTH-1:0] load_b,
   input  logic [WIDTH-1:0] sum,
   input  logic             cout,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mcand
);

   logic [2*WIDTH-1:0] shifted;

   // lo[0] selects whether this iteration takes the ALU sum (with its carry) or plain hi.
   always_comb begin
      shifted = {1'b0, hi, lo[WIDTH-1:1]};
      if (lo[0]) begin
         shifted = {cout, sum, lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
      end else if (load) begin
         hi    <= '0;
         lo    <= load_b;
         mcand <= load_a;
      end else if (step && !stall) begin
         hi <= shifted[2*WIDTH-1:WIDTH];
         lo <= shifted[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle unsigned multiplier that borrows the shared ALU adder for WIDTH
// shift-add iterations, with start/busy/done handshake and grant-based stalling.
module alu_mult_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               alu_req,
   input  logic               alu_grant,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [2:0]         alu_op,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic               alu_cout,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] mcand;
   logic             load;
   logic             running;

   assign running = (state == SEQ_RUN);
   assign load    = (state == SEQ_IDLE) && start;

   mult_shift_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .step   (running),
      .stall  (!alu_grant),
      .load_a (multiplicand),
      .load_b (multiplier),
      .sum    (alu_result),
      .cout   (alu_cout),
      .hi     (hi),
      .lo     (lo),
      .mcand  (mcand)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SEQ_IDLE;
         count <= '0;
      end else begin
         case (state)
            SEQ_IDLE: begin
               if (start) begin
                  count <= '0;
                  state <= SEQ_RUN;
               end
            end
            SEQ_RUN: begin
               if (alu_grant) begin
                  count <= count + 1'b1;
                  if (count == CNT_W'(WIDTH - 1)) begin
                     state <= SEQ_DONE;
                  end
               end
            end
            SEQ_DONE: state <= SEQ_IDLE;
            default:  state <= SEQ_IDLE;
         endcase
      end
   end

   always_comb begin
      alu_req = 1'b0;
      alu_a   = '0;
      alu_b   = '0;
      alu_op  = ALUOP_AND;
      if (running) begin
         alu_req = 1'b1;
         alu_a   = hi;
         alu_b   = mcand;
         alu_op  = ALUOP_ADD;
      end
   end

   assign busy    = running;
   assign done    = (state == SEQ_DONE);
   assign product = {hi, lo};

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer: expected products are queued at start
// and checked when done pulses; cycle-level handshake checks run alongside.
module tb_alu_mult_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        alu_req;
   logic        alu_grant;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_cout;
   logic        busy;
   logic        done;
   logic [63:0] product;

   int checks = 0;
   int errors = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   // Shared ALU adder seen by the sequencer.
   assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

   alu_mult_sequencer #(
      .WIDTH (32),
      .CNT_W (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .alu_req      (alu_req),
      .alu_grant    (alu_grant),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_cout     (alu_cout),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: compare the product against the oldest queued expectation on done.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            check("product", product, sb.pop_front());
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall_len,
                         input bit dbl_start, input bit do_reset);
      int lat;
      logic [63:0] exp;
      logic [63:0] snap;
      lat  = 33 + stall_len;
      snap = '0;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      exp          = {32'd0, a};
      exp          = exp * {32'd0, b};
      sb.push_back(exp);
      for (int n = 1; n <= lat + 1; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (do_reset && n >= 17) begin
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_done", {63'd0, done}, 64'd0);
            check("rst_product", product, 64'd0);
            reset = 1'b0;
            if (n == 20) break;
            continue;
         end
         check("busy", {63'd0, busy}, {63'd0, (n < lat)});
         check("done", {63'd0, done}, {63'd0, (n == lat)});
         check("alu_req", {63'd0, alu_req}, {63'd0, (n < lat)});
         check("alu_op", {61'd0, alu_op}, (n < lat) ? 64'd4 : 64'd0);
         if (stall_len > 0) begin
            if (n == 11) snap = product;
            if (n > 11 && n <= 11 + stall_len) check("stall_hold", product, snap);
         end
         alu_grant = !(stall_len > 0 && n >= 11 && n < 11 + stall_len);
         if (dbl_start && n == 4) begin
            start        = 1'b1;
            multiplicand = 32'h0000_1111;
            multiplier   = 32'h0000_2222;
         end
         if (do_reset && n == 16) begin
            reset = 1'b1;
            sb.delete();
         end
      end
      alu_grant = 1'b1;
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b1;
      multiplicand = 32'd9;
      multiplier   = 32'd9;
      alu_grant    = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_req", {63'd0, alu_req}, 64'd0);
      check("reset_product", product, 64'd0);
      check("reset_alu_a", {32'd0, alu_a}, 64'd0);
      check("reset_alu_b", {32'd0, alu_b}, 64'd0);
      check("reset_alu_op", {61'd0, alu_op}, 64'd0);
      reset = 1'b0;
      start = 1'b0;

      run_op(32'd3, 32'd5, 0, 1'b0, 1'b0);
      check("prod_3x5", product, 64'h0000_0000_0000_000F);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
      check("prod_ones", product, 64'hFFFF_FFFE_0000_0001);
      run_op(32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b0, 1'b0);
      run_op(32'hCAFE_0001, 32'h0000_BEEF, 0, 1'b1, 1'b0);
      run_op(32'hAAAA_5555, 32'h1357_9BDF, 0, 1'b0, 1'b1);
      run_op(32'd7, 32'd6, 0, 1'b0, 1'b0);
      check("prod_7x6", product, 64'd42);
      run_op(32'd0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_product", product, 64'd0);
         check("idle_done", {63'd0, done}, 64'd0);
      end
      for (int i = 0; i < 3; i++) begin
         run_op($urandom, $urandom, (i == 1) ? 3 : 0, 1'b0, 1'b0);
      end
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
